pipe_arbiter: RTL

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/pipe_arbiter.sv
// pipe_arbiter: two requesters share one 3-stage +1/+1 pipeline with alternating-priority arbitration
// Ports:
//   clock_i, reset_i        clock and async active-high reset
//   reqN_valid_i/data_i     operand offer from requester N (N = 0, 1)
//   reqN_ready_o            operand from requester N accepted this cycle
//   flush_i                 discard everything in flight at the next edge
//   out_valid_o/data_o/id_o stage-3 result and the requester it belongs to
//   out_ready_i             consumer takes the result
//   occupancy_o             number of valid stages
module pipe_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_id_o,
  input  logic             out_ready_i,
  output logic [1:0]       occupancy_o
);
  logic [WIDTH-1:0] d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic id1_q, id2_q, id3_q, id1_d, id2_d, id3_d;
  logic lg_q, lg_d;
  logic [1:0] occ_q, occ_d;
  logic adv, g0, g1, acc;
  always_comb begin
    adv = !v3_q | out_ready_i;
    // on a tie, requester 1 wins only if requester 0 was granted last
    g1 = req1_valid_i & (!req0_valid_i | !lg_q);
    g0 = req0_valid_i & !g1;
    // reset term keeps both readies low while reset is held, even between edges
    req0_ready_o = g0 & adv & !flush_i & !reset_i;
    req1_ready_o = g1 & adv & !flush_i & !reset_i;
    acc = req0_ready_o | req1_ready_o;
    v1_d = flush_i ? 1'b0 : adv ? acc : v1_q;
    v2_d = flush_i ? 1'b0 : adv ? v1_q : v2_q;
    v3_d = flush_i ? 1'b0 : adv ? v2_q : v3_q;
    d1_d = adv ? (req1_ready_o ? req1_data_i : req0_ready_o ? req0_data_i : '0) : d1_q;
    d2_d = adv ? d1_q + 1'b1 : d2_q;
    d3_d = adv ? d2_q + 1'b1 : d3_q;
    id1_d = adv ? req1_ready_o : id1_q;
    id2_d = adv ? id1_q : id2_q;
    id3_d = adv ? id2_q : id3_q;
    lg_d = acc ? req1_ready_o : lg_q;
    occ_d = {1'b0, v1_d} + {1'b0, v2_d} + {1'b0, v3_d};
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      {v1_q, v2_q, v3_q} <= '0;
      {id1_q, id2_q, id3_q} <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      lg_q <= 1'b1;
      occ_q <= '0;
    end else begin
      {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
      {id1_q, id2_q, id3_q} <= {id1_d, id2_d, id3_d};
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      lg_q <= lg_d;
      occ_q <= occ_d;
    end
  end
  assign out_valid_o = v3_q;
  assign out_data_o = d3_q;
  assign out_id_o = id3_q;
  assign occupancy_o = occ_q;
endmodule
